jdebug_fastram_master: RTL and testbench

Host-driven fastram bus initiator for the JTAG debug path. It accepts 256-bit command words written by the debug host and turns each one into a single fastram transaction: drives `addr`/`wr`/`ram_req`, waits for `ram_ack`, then returns a 256-bit status word carrying read data and outcome. It sits beside the fastram capture tap. Its status word feeds a capture instance's `d` input, and its command word is taken from a capture instance's `q`/`update` pair.

---
 rtl/jdebug_pkg.sv | 54 +++++
 rtl/jdebug_wait_counter.sv | 24 ++
 rtl/jdebug_fastram_master.sv | 124 ++++++++++++
 tb/tb_jdebug_fastram_master.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/jdebug_pkg.sv
// Shared field layout, state encoding and status packing for the JTAG fastram master.
package jdebug_pkg;

  localparam int CMD_W     = 256;
  localparam int STATUS_W  = 256;
  localparam int ADDR_W    = 24;
  localparam int DATA_W    = 16;
  localparam int TAG_W     = 8;
  localparam int WAIT_W    = 16;

  localparam int CMD_ADDR_LSB  = 0;
  localparam int CMD_WR_BIT    = 24;
  localparam int CMD_WDATA_LSB = 32;
  localparam int CMD_TAG_LSB   = 48;

  localparam int ST_ADDR_LSB    = 0;
  localparam int ST_WR_BIT      = 24;
  localparam int ST_TIMEOUT_BIT = 25;
  localparam int ST_DONE_BIT    = 26;
  localparam int ST_OVERRUN_BIT = 27;
  localparam int ST_RDATA_LSB   = 32;
  localparam int ST_TAG_LSB     = 48;
  localparam int ST_WAIT_LSB    = 56;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    REQ  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [STATUS_W-1:0] build_status(
    input logic [ADDR_W-1:0] addr,
    input logic              wr,
    input logic              timeout,
    input logic              overrun,
    input logic [DATA_W-1:0] rdata,
    input logic [TAG_W-1:0]  tag,
    input logic [WAIT_W-1:0] wait_count
  );
    logic [STATUS_W-1:0] word;
    word = '0;
    word[ST_ADDR_LSB +: ADDR_W]  = addr;
    word[ST_WR_BIT]              = wr;
    word[ST_TIMEOUT_BIT]         = timeout;
    word[ST_DONE_BIT]            = ~timeout;
    word[ST_OVERRUN_BIT]         = overrun;
    word[ST_RDATA_LSB +: DATA_W] = rdata;
    word[ST_TAG_LSB +: TAG_W]    = tag;
    word[ST_WAIT_LSB +: WAIT_W]  = wait_count;
    return word;
  endfunction

endpackage

// File: rtl/jdebug_wait_counter.sv
// Saturating wait counter with synchronous clear and an equality compare against a limit.
module jdebug_wait_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == limit);

endmodule

// File: rtl/jdebug_fastram_master.sv
// Host-driven fastram initiator: one command word in, one fastram transaction, one status word out.
// Optional abort-on-timeout is enabled by defining JDEBUG_FASTRAM_TIMEOUT_EN.
module jdebug_fastram_master
  import jdebug_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CMD_W-1:0]    cmd,
  input  logic                cmd_update,
  input  logic                clk7_en,
  output logic [ADDR_W-1:0]   addr,
  output logic                wr,
  output logic [DATA_W-1:0]   wdata,
  output logic                ram_req,
  input  logic                ram_ack,
  input  logic [DATA_W-1:0]   rdata,
  output logic [STATUS_W-1:0] status,
  output logic                status_valid,
  output logic                busy
);

`ifdef JDEBUG_FASTRAM_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t              state_reg;
  logic [TAG_W-1:0]    tag_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic                timeout_reg;
  logic                overrun_reg;
  logic [WAIT_W-1:0]   wait_count;
  logic                at_limit;
  logic                accept;
  logic                timeout_hit;
  logic                count_en;
  logic                unused_cmd_bits;

  assign unused_cmd_bits = ^{cmd[CMD_W-1:CMD_TAG_LSB+TAG_W], cmd[CMD_WDATA_LSB-1:CMD_WR_BIT+1]};

  // busy is still high during the status_valid cycle, so a command there is an overrun.
  assign accept      = (state_reg == IDLE) && !busy && cmd_update;
  assign timeout_hit = TIMEOUT_EN && at_limit;
  assign count_en    = ((state_reg == ARM) && clk7_en) ||
                       ((state_reg == REQ) && !ram_ack && !timeout_hit);

  jdebug_wait_counter #(
    .WIDTH (WAIT_W)
  ) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .enable   (count_en),
    .limit    (WAIT_W'(TIMEOUT_CYCLES)),
    .count    (wait_count),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      addr         <= '0;
      wr           <= 1'b0;
      wdata        <= '0;
      tag_reg      <= '0;
      rdata_reg    <= '0;
      timeout_reg  <= 1'b0;
      overrun_reg  <= 1'b0;
      ram_req      <= 1'b0;
      status       <= '0;
      status_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      status_valid <= 1'b0;
      if (cmd_update && !accept) begin
        overrun_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          busy <= accept;
          if (accept) begin
            addr      <= cmd[CMD_ADDR_LSB +: ADDR_W];
            wr        <= cmd[CMD_WR_BIT];
            wdata     <= cmd[CMD_WDATA_LSB +: DATA_W];
            tag_reg   <= cmd[CMD_TAG_LSB +: TAG_W];
            state_reg <= ARM;
          end
        end
        ARM: begin
          if (clk7_en) begin
            ram_req   <= 1'b1;
            state_reg <= REQ;
          end
        end
        REQ: begin
          // Ack wins over a timeout landing in the same cycle.
          if (ram_ack) begin
            rdata_reg   <= wr ? '0 : rdata;
            timeout_reg <= 1'b0;
            ram_req     <= 1'b0;
            state_reg   <= DONE;
          end else if (timeout_hit) begin
            rdata_reg   <= '0;
            timeout_reg <= 1'b1;
            ram_req     <= 1'b0;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          status       <= build_status(addr, wr, timeout_reg, overrun_reg | cmd_update,
                                       rdata_reg, tag_reg, wait_count);
          status_valid <= 1'b1;
          overrun_reg  <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jdebug_fastram_master.sv
// Directed bench for jdebug_fastram_master; timeout path depends on JDEBUG_FASTRAM_TIMEOUT_EN.
module tb_jdebug_fastram_master;

  logic         clk;
  logic         reset;
  logic [255:0] cmd;
  logic         cmd_update;
  logic         clk7_en;
  logic [23:0]  addr;
  logic         wr;
  logic [15:0]  wdata;
  logic         ram_req;
  logic         ram_ack;
  logic [15:0]  rdata;
  logic [255:0] status;
  logic         status_valid;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit en7_sparse = 0;
  logic last_en7 = 0;

  jdebug_fastram_master #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd          (cmd),
    .cmd_update   (cmd_update),
    .clk7_en      (clk7_en),
    .addr         (addr),
    .wr           (wr),
    .wdata        (wdata),
    .ram_req      (ram_req),
    .ram_ack      (ram_ack),
    .rdata        (rdata),
    .status       (status),
    .status_valid (status_valid),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one clock; last_en7 records the clk7_en value sampled at that edge.
  task automatic tick();
    @(posedge clk);
    last_en7 = clk7_en;
    #1;
    cyc++;
    clk7_en = en7_sparse ? ((cyc % 4) == 0) : 1'b1;
  endtask

  task automatic send_cmd(input logic [23:0] a, input logic w, input logic [15:0] wd, input logic [7:0] tg);
    cmd = '0;
    cmd[23:0]  = a;
    cmd[24]    = w;
    cmd[31:25] = 7'h7F;
    cmd[47:32] = wd;
    cmd[55:48] = tg;
    cmd[255:56] = {200{1'b1}};
    cmd_update = 1'b1;
    tick();
    cmd_update = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!ram_req && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, ram_req, 1'b1);
    chk({tag, "_en7"}, last_en7, 1'b1);
  endtask

  // Send, launch, hold REQ for `extra` cycles, ack; ends in the status_valid cycle.
  task automatic do_txn(input string tag, input logic [23:0] a, input logic w, input logic [15:0] wd,
                        input logic [7:0] tg, input logic [15:0] rd, input int extra);
    send_cmd(a, w, wd, tg);
    wait_req(tag);
    for (int i = 0; i < extra; i++) tick();
    ram_ack = 1'b1;
    rdata   = rd;
    tick();
    ram_ack = 1'b0;
    rdata   = 16'h0;
    chk({tag, "_req_drop"}, ram_req, 1'b0);
    tick();
    chk({tag, "_valid"}, status_valid, 1'b1);
  endtask

  initial begin
    int n;
    reset = 1'b1; cmd = '0; cmd_update = 1'b0; clk7_en = 1'b0; ram_ack = 1'b0; rdata = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ram_req", ram_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", {wdata, wr, addr}, 41'h0);
    chk("rst_status", {status, status_valid}, 257'h0);

    // Read with sparse 7 MHz enable, ack in the third REQ cycle.
    en7_sparse = 1;
    send_cmd(24'h200010, 1'b0, 16'h0000, 8'h5A);
    chk("rd_accept_busy", busy, 1'b1);
    wait_req("rd");
    chk("rd_addr_out", {wr, addr}, {1'b0, 24'h200010});
    tick(); tick();
    ram_ack = 1'b1; rdata = 16'hBEEF;
    tick();
    ram_ack = 1'b0; rdata = 16'h0;
    chk("rd_req_drop", ram_req, 1'b0);
    chk("rd_no_early_valid", status_valid, 1'b0);
    tick();
    chk("rd_valid", status_valid, 1'b1);
    chk("rd_busy_in_valid", busy, 1'b1);
    chk("rd_status", status, {184'd0, 72'h0003_5A_BEEF_04200010});
    tick();
    chk("rd_busy_drop", {busy, status_valid}, 2'b00);
    en7_sparse = 0;
    tick();

    // Write, launched on the cycle after accept since clk7_en is high.
    send_cmd(24'h000123, 1'b1, 16'h1234, 8'h11);
    chk("wr_arm_no_req", ram_req, 1'b0);
    tick();
    chk("wr_launch", ram_req, 1'b1);
    chk("wr_wdata", wdata, 16'h1234);
    ram_ack = 1'b1; rdata = 16'hFFFF;
    tick();
    ram_ack = 1'b0; rdata = 16'h0;
    tick();
    chk("wr_valid", status_valid, 1'b1);
    chk("wr_status", status, {184'd0, 72'h0001_11_0000_05000123});
    tick();

    // Overrun: second command during REQ is dropped and flagged once.
    send_cmd(24'h000040, 1'b0, 16'h0, 8'h21);
    wait_req("ov");
    send_cmd(24'h000080, 1'b0, 16'h0, 8'h22);
    ram_ack = 1'b1; rdata = 16'h00AA;
    tick();
    ram_ack = 1'b0; rdata = 16'h0;
    tick();
    chk("ov_status", status, {184'd0, 72'h0002_21_00AA_0C000040});
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ram_req || busy) n++;
    end
    chk("ov_dropped_no_txn", n, 0);
    do_txn("ov2", 24'h000050, 1'b0, 16'h0, 8'h23, 16'h0001, 0);
    chk("ov2_status", status, {184'd0, 72'h0001_23_0001_04000050});

    // Command coinciding with status_valid is an overrun as well.
    send_cmd(24'h000060, 1'b0, 16'h0, 8'h99);
    chk("b2b_dropped", {busy, ram_req}, 2'b00);
    tick();
    do_txn("b2b", 24'h000070, 1'b0, 16'h0, 8'h24, 16'h0002, 0);
    chk("b2b_status", status, {184'd0, 72'h0001_24_0002_0C000070});
    tick();

`ifdef JDEBUG_FASTRAM_TIMEOUT_EN
    send_cmd(24'h000300, 1'b0, 16'h0, 8'h31);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (ram_req) n++;
      if (!ram_req && n > 0) break;
      tick();
    end
    chk("to_req_cycles", n, 8);
    tick();
    chk("to_valid", status_valid, 1'b1);
    chk("to_status", status, {184'd0, 72'h0008_31_0000_02000300});
`else
    do_txn("noto", 24'h000300, 1'b0, 16'h0, 8'h31, 16'h5555, 9);
    chk("noto_status", status, {184'd0, 72'h000A_31_5555_04000300});
`endif
    tick();

    // Reset while in REQ.
    send_cmd(24'h000400, 1'b0, 16'h0, 8'h41);
    wait_req("rst");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_outs", {ram_req, busy, status_valid}, 3'b000);
    chk("rst_mid_status", status, 256'h0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (status_valid) n++;
    end
    chk("rst_no_publish", n, 0);
    do_txn("rst2", 24'h000500, 1'b0, 16'h0, 8'h51, 16'h0A0A, 0);
    chk("rst2_status", status, {184'd0, 72'h0001_51_0A0A_04000500});
    tick();

    // Stray ack in IDLE.
    ram_ack = 1'b1; rdata = 16'hDEAD;
    tick();
    ram_ack = 1'b0;
    chk("stray_outs", {busy, ram_req, status_valid}, 3'b000);
    tick();
    chk("stray_no_valid", status_valid, 1'b0);
    chk("stray_status", status, {184'd0, 72'h0001_51_0A0A_04000500});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
